// File: rtl/iq_pkg.sv
// Shared definitions for the ALU issue queue.
// Holds the 21-bit entry layout (field positions), the entry width and the
// physical register tag width used by the queue top level and its slots.
package iq_pkg;

  localparam int TAG_W      = 5;
  localparam int IQ_ENTRY_W = 21;

  // Entry field positions
  localparam int IQ_ISSUED  = 0;
  localparam int IQ_VALID   = 1;
  localparam int IQ_DST_LO  = 2;
  localparam int IQ_RDYA    = 7;
  localparam int IQ_TAGA_LO = 8;
  localparam int IQ_DSTWR   = 13;
  localparam int IQ_RDYB    = 14;
  localparam int IQ_TAGB_LO = 15;
  localparam int IQ_RSVD    = 20;

endpackage

// File: rtl/iq_slot.sv
// One issue-queue slot: a single 21-bit entry register plus the four-way
// wakeup tag compare for both sources.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   flush         clear the slot (highest priority)
//   alloc         dispatch writes alloc_word into this (free) slot
//   alloc_word    entry word from the dispatch lane that owns this slot
//   grant         select grant; clears the slot if it is valid
//   wk_tag/wk_en  the four wakeup broadcasts (ALU0, ALU1, LS, MD)
//   entry         registered slot contents
module iq_slot
  import iq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [IQ_ENTRY_W-1:0]      alloc_word,
  input  logic                       grant,
  input  logic [3:0][TAG_W-1:0]      wk_tag,
  input  logic [3:0]                 wk_en,
  output logic [IQ_ENTRY_W-1:0]      entry
);

  logic [IQ_ENTRY_W-1:0] entry_p0;
  logic [IQ_ENTRY_W-1:0] base_word;
  logic [IQ_ENTRY_W-1:0] upd_word;
  logic [TAG_W-1:0]      tag_a;
  logic [TAG_W-1:0]      tag_b;

  function automatic logic tag_hit(input logic [TAG_W-1:0]        tag,
                                   input logic [3:0][TAG_W-1:0]   bt,
                                   input logic [3:0]              be);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit = hit | (be[i] && (bt[i] == tag));
    end
    return hit;
  endfunction

  // The same compare serves both the stored entry (wakeup) and the word being
  // dispatched (bypass), so a broadcast in the dispatch cycle is never lost.
  always_comb begin
    base_word = alloc ? alloc_word : entry_p0;
    if (alloc) begin
      base_word[IQ_ISSUED] = 1'b0;
      base_word[IQ_VALID]  = 1'b1;
      base_word[IQ_RSVD]   = 1'b0;
    end
    tag_a = base_word[IQ_TAGA_LO +: TAG_W];
    tag_b = base_word[IQ_TAGB_LO +: TAG_W];
    upd_word = base_word;
    upd_word[IQ_RDYA] = base_word[IQ_RDYA] | tag_hit(tag_a, wk_tag, wk_en);
    upd_word[IQ_RDYB] = base_word[IQ_RDYB] | tag_hit(tag_b, wk_tag, wk_en);
  end

  // Slot register: flush > grant (valid only) > dispatch write > wakeup
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_p0 <= '0;
    end else if (flush) begin
      entry_p0 <= '0;
    end else if (grant && entry_p0[IQ_VALID]) begin
      entry_p0 <= '0;
    end else if (alloc || entry_p0[IQ_VALID]) begin
      entry_p0 <= upd_word;
    end
  end

  assign entry = entry_p0;

endmodule

// File: rtl/issue_queue_alu.sv
// Seven-entry ALU issue queue (storage side of the select/wakeup loop).
// Accepts up to two micro-ops per cycle, tracks source readiness from four
// wakeup broadcasts, exposes every slot to select, and frees granted slots.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      clear all slots (iq_overflow kept)
//   disp_en0/1, disp_entry0/1  dispatch lanes
//   disp_ready                 at least two free slots
//   free_cnt                   number of free slots
//   iq_overflow                sticky: a dispatch lane found no free slot
//   IQ_ALU_dout0..6            slot contents
//   IQ_ALU_select_en           grant vector from select
//   wakeup_reg_* / wakeup_*_en wakeup tag broadcasts
module issue_queue_alu #(
  parameter int ENTRIES = 7,
  parameter int TAG_W   = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          disp_en0,
  input  logic                          disp_en1,
  input  logic [iq_pkg::IQ_ENTRY_W-1:0] disp_entry0,
  input  logic [iq_pkg::IQ_ENTRY_W-1:0] disp_entry1,
  output logic                          disp_ready,
  output logic [2:0]                    free_cnt,
  output logic                          iq_overflow,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout0,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout1,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout2,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout3,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout4,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout5,
  output logic [iq_pkg::IQ_ENTRY_W-1:0] IQ_ALU_dout6,
  input  logic [ENTRIES-1:0]            IQ_ALU_select_en,
  input  logic [TAG_W-1:0]              wakeup_reg_ALU0,
  input  logic [TAG_W-1:0]              wakeup_reg_ALU1,
  input  logic [TAG_W-1:0]              wakeup_reg_LS,
  input  logic [TAG_W-1:0]              wakeup_reg_MD,
  input  logic                          wakeup_ALU_en0,
  input  logic                          wakeup_ALU_en1,
  input  logic                          wakeup_LS_en,
  input  logic                          wakeup_MD_en
);

  import iq_pkg::*;

  logic [IQ_ENTRY_W-1:0] slot_q     [ENTRIES];
  logic [IQ_ENTRY_W-1:0] alloc_word [ENTRIES];
  logic [ENTRIES-1:0]    valid_v;
  logic [ENTRIES-1:0]    free_v;
  logic [ENTRIES-1:0]    sel0;
  logic [ENTRIES-1:0]    sel1;
  logic [ENTRIES-1:0]    mask1;
  logic [ENTRIES-1:0]    alloc_v;
  logic                  found0;
  logic                  found1;
  logic                  drop;
  logic                  ovf_p0;
  logic [3:0][TAG_W-1:0] wk_tag;
  logic [3:0]            wk_en;

  function automatic logic [2:0] popcount(input logic [ENTRIES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

  assign wk_tag = {wakeup_reg_MD, wakeup_reg_LS, wakeup_reg_ALU1, wakeup_reg_ALU0};
  assign wk_en  = {wakeup_MD_en, wakeup_LS_en, wakeup_ALU_en1, wakeup_ALU_en0};

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_v[i] = slot_q[i][IQ_VALID];
    end
  end

  // Free slots come only from registered valid bits: a slot granted this
  // cycle is still seen as occupied and cannot be reused until next cycle.
  assign free_v = ~valid_v;

  // Two-lane lowest-index free-slot finder. Lane 1 skips lane 0's pick only
  // when lane 0 is actually dispatching.
  always_comb begin
    found0 = 1'b0;
    sel0   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (free_v[i] && !found0) begin
        found0  = 1'b1;
        sel0[i] = 1'b1;
      end
    end
    mask1  = free_v & ~((disp_en0 && found0) ? sel0 : '0);
    found1 = 1'b0;
    sel1   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (mask1[i] && !found1) begin
        found1  = 1'b1;
        sel1[i] = 1'b1;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_v[i]    = (disp_en0 && sel0[i]) || (disp_en1 && sel1[i]);
      alloc_word[i] = (disp_en0 && sel0[i]) ? disp_entry0 : disp_entry1;
    end
  end

  // Dispatch is discarded during flush, so a drop only counts outside flush.
  assign drop = !flush && ((disp_en0 && !found0) || (disp_en1 && !found1));

  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    iq_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc      (alloc_v[g]),
      .alloc_word (alloc_word[g]),
      .grant      (IQ_ALU_select_en[g]),
      .wk_tag     (wk_tag),
      .wk_en      (wk_en),
      .entry      (slot_q[g])
    );
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_p0 <= 1'b0;
    end else if (drop) begin
      ovf_p0 <= 1'b1;
    end
  end

  assign iq_overflow  = ovf_p0;
  assign free_cnt     = popcount(free_v);
  assign disp_ready   = (free_cnt >= 3'd2);

  assign IQ_ALU_dout0 = slot_q[0];
  assign IQ_ALU_dout1 = slot_q[1];
  assign IQ_ALU_dout2 = slot_q[2];
  assign IQ_ALU_dout3 = slot_q[3];
  assign IQ_ALU_dout4 = slot_q[4];
  assign IQ_ALU_dout5 = slot_q[5];
  assign IQ_ALU_dout6 = slot_q[6];

endmodule

// File: tb/tb_issue_queue_alu.sv
// Directed self-checking bench for issue_queue_alu.
module tb_issue_queue_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_en0, disp_en1;
  logic [20:0] disp_entry0, disp_entry1;
  logic        disp_ready;
  logic [2:0]  free_cnt;
  logic        iq_overflow;
  logic [20:0] d0, d1, d2, d3, d4, d5, d6;
  logic [6:0]  select_en;
  logic [4:0]  wk_alu0, wk_alu1, wk_ls, wk_md;
  logic        wk_alu0_en, wk_alu1_en, wk_ls_en, wk_md_en;
  logic [20:0] dout [7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_queue_alu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .disp_en0         (disp_en0),
    .disp_en1         (disp_en1),
    .disp_entry0      (disp_entry0),
    .disp_entry1      (disp_entry1),
    .disp_ready       (disp_ready),
    .free_cnt         (free_cnt),
    .iq_overflow      (iq_overflow),
    .IQ_ALU_dout0     (d0),
    .IQ_ALU_dout1     (d1),
    .IQ_ALU_dout2     (d2),
    .IQ_ALU_dout3     (d3),
    .IQ_ALU_dout4     (d4),
    .IQ_ALU_dout5     (d5),
    .IQ_ALU_dout6     (d6),
    .IQ_ALU_select_en (select_en),
    .wakeup_reg_ALU0  (wk_alu0),
    .wakeup_reg_ALU1  (wk_alu1),
    .wakeup_reg_LS    (wk_ls),
    .wakeup_reg_MD    (wk_md),
    .wakeup_ALU_en0   (wk_alu0_en),
    .wakeup_ALU_en1   (wk_alu1_en),
    .wakeup_LS_en     (wk_ls_en),
    .wakeup_MD_en     (wk_md_en)
  );

  assign dout[0] = d0;
  assign dout[1] = d1;
  assign dout[2] = d2;
  assign dout[3] = d3;
  assign dout[4] = d4;
  assign dout[5] = d5;
  assign dout[6] = d6;

  // Valid entry word with issued=0 and reserved=0
  function automatic logic [20:0] mk(input logic [4:0] dst, input logic [4:0] ta,
                                     input logic ra, input logic [4:0] tb,
                                     input logic rb, input logic dw);
    logic [20:0] w;
    w = '0;
    w[1]     = 1'b1;
    w[6:2]   = dst;
    w[7]     = ra;
    w[12:8]  = ta;
    w[13]    = dw;
    w[14]    = rb;
    w[19:15] = tb;
    return w;
  endfunction

  task automatic idle_inputs();
    flush = 0; disp_en0 = 0; disp_en1 = 0; disp_entry0 = '0; disp_entry1 = '0;
    select_en = '0;
    wk_alu0 = '0; wk_alu1 = '0; wk_ls = '0; wk_md = '0;
    wk_alu0_en = 0; wk_alu1_en = 0; wk_ls_en = 0; wk_md_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    // dirty the queue first so reset has something to discard
    disp_en0 = 1; disp_entry0 = mk(5'd1, 5'd2, 1, 5'd3, 1, 1);
    step();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dout[i] !== 21'h0) begin
        errors++; $display("FAIL reset_dout%0d got %h want 0", i, dout[i]);
      end
    end
    checks++;
    if (free_cnt !== 3'd7) begin errors++; $display("FAIL reset_free_cnt got %0d want 7", free_cnt); end
    checks++;
    if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
    checks++;
    if (iq_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", iq_overflow); end
  endtask

  task automatic test_dispatch_bypass();
    disp_en0 = 1; disp_entry0 = mk(5'd5, 5'd3, 1, 5'd4, 0, 1);
    disp_en1 = 1; disp_entry1 = mk(5'd6, 5'd1, 1, 5'd2, 1, 1);
    wk_ls = 5'd4; wk_ls_en = 1;
    step();
    idle_inputs();
    checks++;
    if (d0 !== mk(5'd5, 5'd3, 1, 5'd4, 1, 1)) begin
      errors++; $display("FAIL bypass_slot0 got %h want %h", d0, mk(5'd5, 5'd3, 1, 5'd4, 1, 1));
    end
    checks++;
    if (d1 !== mk(5'd6, 5'd1, 1, 5'd2, 1, 1)) begin
      errors++; $display("FAIL bypass_slot1 got %h want %h", d1, mk(5'd6, 5'd1, 1, 5'd2, 1, 1));
    end
    checks++;
    if (free_cnt !== 3'd5) begin errors++; $display("FAIL bypass_free_cnt got %0d want 5", free_cnt); end
  endtask

  task automatic test_wakeup_later();
    disp_en0 = 1; disp_entry0 = mk(5'd7, 5'd8, 1, 5'd9, 0, 0);
    step();
    idle_inputs();
    checks++;
    if (d2 !== mk(5'd7, 5'd8, 1, 5'd9, 0, 0)) begin
      errors++; $display("FAIL wake_slot2_waiting got %h want %h", d2, mk(5'd7, 5'd8, 1, 5'd9, 0, 0));
    end
    wk_md = 5'd9; wk_md_en = 1;
    #2;
    checks++;
    if (d2[14] !== 1'b0) begin errors++; $display("FAIL wake_before_edge got %b want 0", d2[14]); end
    step();
    idle_inputs();
    checks++;
    if (d2 !== mk(5'd7, 5'd8, 1, 5'd9, 1, 0)) begin
      errors++; $display("FAIL wake_after_edge got %h want %h", d2, mk(5'd7, 5'd8, 1, 5'd9, 1, 0));
    end
    checks++;
    if (free_cnt !== 3'd4) begin errors++; $display("FAIL wake_free_cnt got %0d want 4", free_cnt); end
  endtask

  task automatic test_grant_reuse();
    disp_en0 = 1; disp_entry0 = mk(5'd10, 5'd11, 0, 5'd12, 0, 1);
    disp_en1 = 1; disp_entry1 = mk(5'd13, 5'd14, 0, 5'd15, 0, 1);
    step();
    idle_inputs();
    checks++;
    if (free_cnt !== 3'd2) begin errors++; $display("FAIL grant_pre_free_cnt got %0d want 2", free_cnt); end
    select_en = 7'b0000011;
    disp_en0 = 1; disp_entry0 = mk(5'd16, 5'd17, 1, 5'd18, 0, 1);
    disp_en1 = 1; disp_entry1 = mk(5'd19, 5'd20, 0, 5'd21, 1, 0);
    step();
    idle_inputs();
    checks++;
    if (d0 !== 21'h0 || d1 !== 21'h0) begin
      errors++; $display("FAIL grant_cleared got %h %h want 0 0", d0, d1);
    end
    checks++;
    if (d5 !== mk(5'd16, 5'd17, 1, 5'd18, 0, 1)) begin
      errors++; $display("FAIL grant_reuse_slot5 got %h want %h", d5, mk(5'd16, 5'd17, 1, 5'd18, 0, 1));
    end
    checks++;
    if (d6 !== mk(5'd19, 5'd20, 0, 5'd21, 1, 0)) begin
      errors++; $display("FAIL grant_reuse_slot6 got %h want %h", d6, mk(5'd19, 5'd20, 0, 5'd21, 1, 0));
    end
    checks++;
    if (d3 !== mk(5'd10, 5'd11, 0, 5'd12, 0, 1)) begin
      errors++; $display("FAIL grant_slot3_kept got %h want %h", d3, mk(5'd10, 5'd11, 0, 5'd12, 0, 1));
    end
    checks++;
    if (free_cnt !== 3'd2) begin errors++; $display("FAIL grant_post_free_cnt got %0d want 2", free_cnt); end
  endtask

  task automatic test_lane1_and_idle_grant();
    do_reset();
    disp_en1 = 1; disp_entry1 = mk(5'd22, 5'd23, 0, 5'd24, 0, 1);
    step();
    idle_inputs();
    checks++;
    if (d0 !== mk(5'd22, 5'd23, 0, 5'd24, 0, 1)) begin
      errors++; $display("FAIL lane1_only_slot0 got %h want %h", d0, mk(5'd22, 5'd23, 0, 5'd24, 0, 1));
    end
    // grant on an invalid slot must not block a dispatch into it
    select_en = 7'b0000010;
    disp_en0 = 1; disp_entry0 = mk(5'd25, 5'd26, 1, 5'd27, 1, 0);
    step();
    idle_inputs();
    checks++;
    if (d1 !== mk(5'd25, 5'd26, 1, 5'd27, 1, 0)) begin
      errors++; $display("FAIL idle_grant_slot1 got %h want %h", d1, mk(5'd25, 5'd26, 1, 5'd27, 1, 0));
    end
    checks++;
    if (free_cnt !== 3'd5) begin errors++; $display("FAIL idle_grant_free_cnt got %0d want 5", free_cnt); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      disp_en0 = 1; disp_entry0 = mk(5'(2 * p), 5'd30, 0, 5'd31, 0, 1);
      disp_en1 = 1; disp_entry1 = mk(5'(2 * p + 1), 5'd30, 0, 5'd31, 0, 1);
      step();
      idle_inputs();
    end
    checks++;
    if (free_cnt !== 3'd1) begin errors++; $display("FAIL fill_free_cnt6 got %0d want 1", free_cnt); end
    checks++;
    if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_disp_ready6 got %b want 0", disp_ready); end
    checks++;
    if (iq_overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow_yet got %b want 0", iq_overflow); end
    disp_en0 = 1; disp_entry0 = mk(5'd20, 5'd30, 0, 5'd31, 0, 1);
    disp_en1 = 1; disp_entry1 = mk(5'd21, 5'd30, 0, 5'd31, 0, 1);
    step();
    idle_inputs();
    checks++;
    if (d6 !== mk(5'd20, 5'd30, 0, 5'd31, 0, 1)) begin
      errors++; $display("FAIL fill_slot6 got %h want %h", d6, mk(5'd20, 5'd30, 0, 5'd31, 0, 1));
    end
    checks++;
    if (free_cnt !== 3'd0) begin errors++; $display("FAIL fill_free_cnt7 got %0d want 0", free_cnt); end
    checks++;
    if (iq_overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_set got %b want 1", iq_overflow); end
    step(); step();
    checks++;
    if (iq_overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky got %b want 1", iq_overflow); end
  endtask

  task automatic test_flush();
    flush = 1;
    disp_en0 = 1; disp_entry0 = mk(5'd1, 5'd2, 0, 5'd3, 0, 1);
    select_en = 7'b0000001;
    wk_alu0 = 5'd30; wk_alu0_en = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dout[i] !== 21'h0) begin
        errors++; $display("FAIL flush_dout%0d got %h want 0", i, dout[i]);
      end
    end
    checks++;
    if (free_cnt !== 3'd7) begin errors++; $display("FAIL flush_free_cnt got %0d want 7", free_cnt); end
    checks++;
    if (iq_overflow !== 1'b1) begin errors++; $display("FAIL flush_overflow_kept got %b want 1", iq_overflow); end
    do_reset();
    checks++;
    if (iq_overflow !== 1'b0) begin errors++; $display("FAIL reset_clears_overflow got %b want 0", iq_overflow); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    test_reset();
    test_dispatch_bypass();
    test_wakeup_later();
    test_grant_reuse();
    test_lane1_and_idle_grant();
    test_fill_overflow();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
